// File: rtl/key_expand_pkg.sv
`default_nettype none
// ==========================================================================
// Module  : key_expand_pkg
// Brief   : Shared AES-128 constants, FSM encodings and GF(2^8) helpers
// Revision: 1.0
// ==========================================================================
package key_expand_pkg;

  localparam logic [3:0] c_NUM_ROUNDS = 4'd10;
  localparam logic [7:0] c_RCON_INIT  = 8'h01;
  localparam logic [7:0] c_RCON_POLY  = 8'h1b;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_EMIT = 1'b1;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? c_RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0 naturally).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_expand_sbox.sv
`default_nettype none
// ==========================================================================
// Module  : key_expand_sbox
// Brief   : AES forward S-box, byte in / byte out (inverse + affine map)
// Revision: 1.0
// ==========================================================================
module key_expand_sbox
  import key_expand_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_inv;

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/key_expand.sv
`default_nettype none
// ==========================================================================
// Module  : key_expand
// Brief   : AES-128 on-the-fly key schedule, one round key per handshake
// Revision: 1.0
// ==========================================================================
module key_expand
  import key_expand_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  logic [0:0]   r_state;
  logic [0:0]   w_state_next;
  logic [127:0] r_rk;
  logic [127:0] w_rk_next;
  logic [3:0]   r_round;
  logic [3:0]   w_round_next;
  logic [7:0]   r_rcon;
  logic [7:0]   w_rcon_next;
  logic         r_done;
  logic         w_done_next;
  logic         w_xfer;

  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_n0;
  logic [31:0]  w_n1;
  logic [31:0]  w_n2;
  logic [31:0]  w_n3;

  // Next round key: SubWord(RotWord(w3)) feeds the word-chained XOR.
  assign w_rot = {r_rk[23:0], r_rk[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    key_expand_sbox u_sbox (
      .i_byte (w_rot[8*i +: 8]),
      .o_byte (w_sub[8*i +: 8])
    );
  end

  assign w_t  = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0 = r_rk[127:96] ^ w_t;
  assign w_n1 = r_rk[95:64]  ^ w_n0;
  assign w_n2 = r_rk[63:32]  ^ w_n1;
  assign w_n3 = r_rk[31:0]   ^ w_n2;

  assign w_xfer = (r_state == c_ST_EMIT) && rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: if (start) w_state_next = c_ST_EMIT;
      c_ST_EMIT: if (w_xfer && (r_round == c_NUM_ROUNDS)) w_state_next = c_ST_IDLE;
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_rk_next    = r_rk;
    w_round_next = r_round;
    w_rcon_next  = r_rcon;
    w_done_next  = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_rk_next    = key_in;
          w_round_next = 4'd0;
          w_rcon_next  = c_RCON_INIT;
        end
      end
      c_ST_EMIT: begin
        if (w_xfer) begin
          if (r_round == c_NUM_ROUNDS) begin
            w_done_next = 1'b1;
          end else begin
            w_rk_next    = {w_n0, w_n1, w_n2, w_n3};
            w_round_next = r_round + 4'd1;
            w_rcon_next  = xtime(r_rcon);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rk    <= '0;
      r_round <= 4'd0;
      r_rcon  <= c_RCON_INIT;
      r_done  <= 1'b0;
    end else begin
      r_rk    <= w_rk_next;
      r_round <= w_round_next;
      r_rcon  <= w_rcon_next;
      r_done  <= w_done_next;
    end
  end

  assign rk       = r_rk;
  assign rk_round = r_round;
  assign rk_valid = (r_state == c_ST_EMIT);
  assign busy     = (r_state != c_ST_IDLE);
  assign done     = r_done;

endmodule
`default_nettype wire

// File: doc/key_expand.md
KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 SHALL expose clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose start  input  1  request to begin expanding key_in; sampled only in IDLE.
REQ-004 SHALL expose key_in  input  128  AES-128 cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
REQ-005 SHALL expose rk_ready  input  1  downstream round stage accepts the current round key.
REQ-006 SHALL expose rk  output  128  current round key, same word order as key_in.
REQ-007 SHALL expose rk_round  output  4  index of rk, 0..10.
REQ-008 SHALL expose rk_valid  output  1  rk/rk_round are valid.
REQ-009 SHALL expose busy  output  1  high whenever the FSM is not IDLE.
REQ-010 SHALL expose done  output  1  one-cycle pulse after round key 10 is accepted.

Function
REQ-011 SHALL implement FSM states IDLE and EMIT, all outputs registered.
REQ-012 IDLE, start=1: SHALL latch key_in into rk, set rk_round=0, rcon=8'h01, enter EMIT; rk_valid=1 on the following cycle (latency 1).
REQ-013 IDLE, start=0: SHALL hold rk, rk_round, rcon; rk_valid=0.
REQ-014 EMIT: rk_valid SHALL be 1; a transfer occurs on a cycle with rk_valid=1 and rk_ready=1.
REQ-015 EMIT, rk_ready=0: rk, rk_round, rcon SHALL hold unchanged (stall, any duration).
REQ-016 EMIT, transfer, rk_round<10: next rk SHALL be the FIPS-197 expansion of the current rk using the current rcon; rk_round increments by 1; rcon updates to xtime(rcon).
REQ-017 Expansion: t = SubWord(RotWord(w3)) XOR {rcon,24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'; computed combinationally in one cycle.
REQ-018 xtime: shift left by 1 within 8 bits, XOR 8'h1b when bit 7 was set; sequence 01,02,04,08,10,20,40,80,1b,36.
REQ-019 EMIT, transfer, rk_round=10: SHALL return to IDLE; next cycle rk_valid=0, done=1 for exactly one cycle; rk and rk_round keep their last values.
REQ-020 start asserted while busy=1 SHALL be ignored and SHALL NOT change key or sequence.
REQ-021 start asserted on the same cycle as the final transfer SHALL be ignored; a new start is accepted from the first IDLE cycle.
REQ-022 rk_round SHALL never exceed 10 and SHALL NOT wrap.
REQ-023 key_in changes after the start cycle SHALL have no effect on the current sequence.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, rk=0, rk_round=0, rk_valid=0, busy=0, done=0, rcon=8'h01, independent of clk.
REQ-025 Reset mid-sequence SHALL abort; after release no round key is emitted until a new start.

Structure
REQ-026 The round count (10), the rcon initial value (8'h01), and the reduction constant (8'h1b) SHALL live in the shared AES package/defines file used by enc_round.
REQ-027 SubWord SHALL instantiate four copies of the existing sbox sub-module (byte in, byte out), the same one used by enc_round; no second S-box table.
REQ-028 The datapath SHALL be one 128-bit register, one 8-bit rcon register, and one 4-bit counter; no storage of all 11 keys.

Verification
REQ-029 key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1 -> rk_round 0 = key_in, 1 = a0fafe1788542cb123a339392a6c7605, 2 = f2c295f27a96b9435935807a7359f67f, 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses once; 11 transfers total.
REQ-030 Same key, rk_ready toggled pseudo-randomly -> identical key sequence; rk held stable during every rk_ready=0 cycle.
REQ-031 start re-pulsed with a different key during round 4 -> ignored; sequence completes with the original key's round keys.
REQ-032 rst asserted during round 6 (mid-cycle, asynchronous) -> outputs zero immediately; new start with key 000102030405060708090a0b0c0d0e0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-033 Back-to-back: start on the first IDLE cycle after done -> second sequence correct; start on the final-transfer cycle -> ignored.
